capture_sequencer: RTL and testbench

CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

---
 rtl/capture_sequencer.sv | 101 ++++++++++
 tb/tb_capture_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
// Capture sequencer: gates per-channel capture enables, counts accepted
// captures and runs a clear (and optional ack wait) once the depth is reached.
module capture_sequencer #(
  parameter int NCH      = 4,
  parameter int DEPTH    = 8,
  parameter int CLR_LEN  = 1,
  parameter int ACK_MODE = 0,
  localparam int SELW    = $clog2(NCH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            capture,
  input  logic [SELW-1:0] op,
  input  logic [NCH-1:0]  mask,
  input  logic            ack,
  output logic [NCH-1:0]  en,
  output logic            clear,
  output logic            full,
  output logic [CW-1:0]   count,
  output logic            busy
);

  localparam int PW = 1 << SELW;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [3:0] TLAST = 4'(CLR_LEN - 1);
  localparam logic [SELW:0] NCH_C = (SELW+1)'(NCH);

  typedef enum logic [1:0] {
    S_CAPT  = 2'd0,
    S_CLEAR = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t state, nxt;
  logic [3:0] timer;
  logic [PW-1:0] mask_p;
  logic [PW-1:0] en_p;
  logic in_capt;
  logic op_ok;
  logic accept;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= S_CAPT;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_CAPT: begin
        if (full) nxt = S_CLEAR;
      end
      S_CLEAR: begin
        if (timer == TLAST)
          nxt = (ACK_MODE != 0) ? S_WAIT : S_CAPT;
      end
      S_WAIT: begin
        if (ack) nxt = S_CAPT;
      end
      default: nxt = S_CAPT;
    endcase
  end

  // Out-of-range selects index a zero-padded mask, so they never accept.
  always_comb begin
    mask_p = '0;
    mask_p[NCH-1:0] = mask;
    in_capt = (state == S_CAPT);
    op_ok = ({1'b0, op} < NCH_C);
    full = in_capt & (count == DEPTH_C);
    accept = ~rst & in_capt & capture & ~full & op_ok & mask_p[op];
    en_p = '0;
    en_p[op] = accept;
    en = en_p[NCH-1:0];
    clear = (state == S_CLEAR);
    busy = ~in_capt;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      count <= '0;
      timer <= '0;
    end else begin
      if (in_capt && full) begin
        count <= '0;
      end else if (accept) begin
        count <= count + CW'(1);
      end
      if (in_capt) begin
        timer <= '0;
      end else if (state == S_CLEAR) begin
        timer <= timer + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: five parameter sets share one stimulus stream
// and are each checked every cycle against a behavioural model.
module tb_capture_sequencer;

  localparam int NI = 5;
  localparam int P_NCH[NI]   = '{4, 4, 2, 8, 5};
  localparam int P_DEPTH[NI] = '{3, 3, 1, 255, 2};
  localparam int P_CLR[NI]   = '{2, 1, 1, 3, 15};
  localparam int P_ACK[NI]   = '{1, 0, 1, 0, 1};

  logic clock;
  logic rst;
  logic capture;
  logic [7:0] op;
  logic [15:0] mask;
  logic ack;

  logic [3:0] en0, en1;
  logic [1:0] en2;
  logic [7:0] en3;
  logic [4:0] en4;
  logic [1:0] count0, count1;
  logic count2;
  logic [7:0] count3;
  logic [1:0] count4;
  logic clear0, clear1, clear2, clear3, clear4;
  logic full0, full1, full2, full3, full4;
  logic busy0, busy1, busy2, busy3, busy4;

  int errors = 0;
  int checks = 0;

  // Model: phase 0 = capturing, 1 = clearing, 2 = waiting for ack.
  int ms[NI];
  int mc[NI];
  int mt[NI];

  capture_sequencer #(.NCH(4), .DEPTH(3), .CLR_LEN(2), .ACK_MODE(1)) u0 (
    .clock(clock), .rst(rst), .capture(capture), .op(op[1:0]),
    .mask(mask[3:0]), .ack(ack), .en(en0), .clear(clear0),
    .full(full0), .count(count0), .busy(busy0));

  capture_sequencer #(.NCH(4), .DEPTH(3), .CLR_LEN(1), .ACK_MODE(0)) u1 (
    .clock(clock), .rst(rst), .capture(capture), .op(op[1:0]),
    .mask(mask[3:0]), .ack(ack), .en(en1), .clear(clear1),
    .full(full1), .count(count1), .busy(busy1));

  capture_sequencer #(.NCH(2), .DEPTH(1), .CLR_LEN(1), .ACK_MODE(1)) u2 (
    .clock(clock), .rst(rst), .capture(capture), .op(op[0:0]),
    .mask(mask[1:0]), .ack(ack), .en(en2), .clear(clear2),
    .full(full2), .count(count2), .busy(busy2));

  capture_sequencer #(.NCH(8), .DEPTH(255), .CLR_LEN(3), .ACK_MODE(0)) u3 (
    .clock(clock), .rst(rst), .capture(capture), .op(op[2:0]),
    .mask(mask[7:0]), .ack(ack), .en(en3), .clear(clear3),
    .full(full3), .count(count3), .busy(busy3));

  capture_sequencer #(.NCH(5), .DEPTH(2), .CLR_LEN(15), .ACK_MODE(1)) u4 (
    .clock(clock), .rst(rst), .capture(capture), .op(op[2:0]),
    .mask(mask[4:0]), .ack(ack), .en(en4), .clear(clear4),
    .full(full4), .count(count4), .busy(busy4));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic c, input int o, input int m, input logic a);
    capture = c;
    op = 8'(o);
    mask = 16'(m);
    ack = a;
  endtask

  // Compare every instance on the falling edge, then advance the model.
  task automatic tick();
    int a_en[NI], a_cnt[NI], a_clr[NI], a_full[NI], a_busy[NI];
    int sw, opk, e_full, acc, e_en;
    @(negedge clock);
    a_en = '{int'(en0), int'(en1), int'(en2), int'(en3), int'(en4)};
    a_cnt = '{int'(count0), int'(count1), int'(count2), int'(count3), int'(count4)};
    a_clr = '{int'(clear0), int'(clear1), int'(clear2), int'(clear3), int'(clear4)};
    a_full = '{int'(full0), int'(full1), int'(full2), int'(full3), int'(full4)};
    a_busy = '{int'(busy0), int'(busy1), int'(busy2), int'(busy3), int'(busy4)};
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        ms[k] = 0;
        mc[k] = 0;
        mt[k] = 0;
      end
      sw = $clog2(P_NCH[k]);
      opk = int'(op) % (1 << sw);
      e_full = (ms[k] == 0 && mc[k] == P_DEPTH[k]) ? 1 : 0;
      acc = (!rst && ms[k] == 0 && capture && e_full == 0 &&
             opk < P_NCH[k] && mask[opk]) ? 1 : 0;
      e_en = acc ? (1 << opk) : 0;
      chk($sformatf("c%0d.en", k), a_en[k], e_en);
      chk($sformatf("c%0d.count", k), a_cnt[k], mc[k]);
      chk($sformatf("c%0d.full", k), a_full[k], e_full);
      chk($sformatf("c%0d.clear", k), a_clr[k], (ms[k] == 1) ? 1 : 0);
      chk($sformatf("c%0d.busy", k), a_busy[k], (ms[k] != 0) ? 1 : 0);
      if (!rst) begin
        if (ms[k] == 0) begin
          if (e_full != 0) begin
            ms[k] = 1;
            mc[k] = 0;
            mt[k] = 0;
          end else begin
            mc[k] += acc;
          end
        end else if (ms[k] == 1) begin
          mt[k]++;
          if (mt[k] == P_CLR[k]) ms[k] = P_ACK[k] ? 2 : 0;
        end else if (ack) begin
          ms[k] = 0;
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    int seen255;
    rst = 1'b1;
    drive(1'b1, 0, 'hF, 1'b0);
    #1;
    chk("rst.en", int'(en0), 0);
    chk("rst.count", int'(count0), 0);
    chk("rst.busy", int'(busy0), 0);
    chk("rst.clear", int'(clear0), 0);
    chk("rst.full", int'(full0), 0);
    tick();
    tick();
    rst = 1'b0;

    drive(1'b1, 0, 'hF, 1'b0);
    #1 chk("dec.en0", int'(en0), 1);
    tick();
    chk("dec.count1", int'(count0), 1);
    chk("d1.full", int'(full2), 1);
    drive(1'b1, 1, 'hF, 1'b0);
    #1 chk("dec.en1", int'(en0), 2);
    tick();
    chk("dec.count2", int'(count0), 2);
    drive(1'b1, 2, 'hF, 1'b0);
    #1 chk("dec.en2", int'(en0), 4);
    tick();
    chk("dec.count3", int'(count0), 3);
    chk("dec.full", int'(full0), 1);
    drive(1'b1, 3, 'hF, 1'b0);
    #1 chk("dec.drop", int'(en0), 0);
    tick();
    chk("clr.clear1", int'(clear0), 1);
    chk("clr.count", int'(count0), 0);
    chk("clr.busy", int'(busy0), 1);
    #1 chk("clr.en", int'(en0), 0);
    tick();
    chk("clr.clear2", int'(clear0), 1);
    chk("a0.busy", int'(busy1), 0);
    chk("a0.count", int'(count1), 0);
    drive(1'b0, 0, 'hF, 1'b0);
    tick();
    chk("wait.clear", int'(clear0), 0);
    chk("wait.busy", int'(busy0), 1);
    tick();
    chk("wait.hold", int'(busy0), 1);
    drive(1'b0, 0, 'hF, 1'b1);
    tick();
    chk("ack.busy", int'(busy0), 0);

    drive(1'b1, 2, 'hB, 1'b0);
    #1 chk("mask.en_off", int'(en0), 0);
    tick();
    chk("mask.count0", int'(count0), 0);
    drive(1'b1, 3, 'hB, 1'b0);
    #1 chk("mask.en_on", int'(en0), 8);
    tick();
    chk("mask.count1", int'(count0), 1);

    drive(1'b1, 0, 'hF, 1'b0);
    tick();
    drive(1'b1, 1, 'hF, 1'b0);
    tick();
    drive(1'b0, 0, 'hF, 1'b0);
    tick();
    chk("mid.clear", int'(clear0), 1);
    rst = 1'b1;
    #1;
    chk("mid.clear_rst", int'(clear0), 0);
    chk("mid.busy_rst", int'(busy0), 0);
    tick();
    rst = 1'b0;
    drive(1'b1, 1, 'hF, 1'b0);
    #1 chk("post.en", int'(en0), 2);
    tick();
    chk("post.count", int'(count0), 1);

    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 7),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : 'hFFFF,
            ($urandom_range(0, 2) == 0));
      tick();
    end

    rst = 1'b0;
    seen255 = 0;
    for (int i = 0; i < 700; i++) begin
      drive(1'b1, $urandom_range(0, 7), 'hFFFF, 1'b1);
      tick();
      if (count3 == 8'd255) seen255 = 1;
    end
    chk("d255.reached", seen255, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
